// File: rtl/chess_pkg.sv
// Shared chess types and display colours for the board renderer.
// The board nibble layout is {colour, piece[2:0]}.
package chess_pkg;

  typedef enum logic [2:0] {
    NONE   = 3'd0,
    PAWN   = 3'd1,
    KNIGHT = 3'd2,
    BISHOP = 3'd3,
    ROOK   = 3'd4,
    QUEEN  = 3'd5,
    KING   = 3'd6,
    MARKER = 3'd7
  } piece_e;

  typedef enum logic {
    COLOR_WHITE = 1'b0,
    COLOR_BLACK = 1'b1
  } color_e;

  typedef struct packed {
    color_e color;
    piece_e piece;
  } square_t;

  typedef logic [7:0] rgb_t;

  // {R[2:0], G[2:0], B[1:0]}
  localparam rgb_t RGB_BLACK       = 8'h00;
  localparam rgb_t RGB_CURSOR      = 8'h03;
  localparam rgb_t RGB_SELECT      = 8'hE0;
  localparam rgb_t RGB_PIECE_BLACK = 8'h25;
  localparam rgb_t RGB_PIECE_WHITE = 8'hFF;
  localparam rgb_t RGB_LAST        = 8'hD8;
  localparam rgb_t RGB_DARK        = 8'hA0;
  localparam rgb_t RGB_LIGHT       = 8'hFA;

  function automatic logic is_piece(input piece_e p);
    return (p >= PAWN) && (p <= KING);
  endfunction

endpackage

// File: rtl/piece_art_rom.sv
// Combinational 8x8 piece bitmaps; row[0] is the leftmost art pixel.
// Empty squares and the marker code have no art.
module piece_art_rom
  import chess_pkg::*;
(
  input  logic [2:0] piece,
  input  logic [2:0] ay,
  output logic [0:7] row
);

  localparam logic [7:0] PAWN_ART [0:7] = '{
    8'b00000000, 8'b00011000, 8'b00111100, 8'b00111100,
    8'b00011000, 8'b00111100, 8'b01111110, 8'b01111110
  };
  localparam logic [7:0] KNIGHT_ART [0:7] = '{
    8'b00000000, 8'b00111000, 8'b01111100, 8'b11101110,
    8'b00011110, 8'b00111100, 8'b01111110, 8'b01111110
  };
  localparam logic [7:0] BISHOP_ART [0:7] = '{
    8'b00011000, 8'b00111100, 8'b00110100, 8'b00111100,
    8'b00011000, 8'b00111100, 8'b01111110, 8'b01111110
  };
  localparam logic [7:0] ROOK_ART [0:7] = '{
    8'b00000000, 8'b01011010, 8'b01111110, 8'b00111100,
    8'b00111100, 8'b00111100, 8'b01111110, 8'b01111110
  };
  localparam logic [7:0] QUEEN_ART [0:7] = '{
    8'b01011010, 8'b01011010, 8'b01111110, 8'b00111100,
    8'b00111100, 8'b00111100, 8'b01111110, 8'b01111110
  };
  localparam logic [7:0] KING_ART [0:7] = '{
    8'b00011000, 8'b00111100, 8'b00011000, 8'b01111110,
    8'b00111100, 8'b00111100, 8'b01111110, 8'b01111110
  };

  always_comb begin
    // NOTE: default first so every path assigns row; a missing branch would infer a latch.
    row = '0;
    case (piece)
      PAWN:    row = PAWN_ART[ay];
      KNIGHT:  row = KNIGHT_ART[ay];
      BISHOP:  row = BISHOP_ART[ay];
      ROOK:    row = ROOK_ART[ay];
      QUEEN:   row = QUEEN_ART[ay];
      KING:    row = KING_ART[ay];
      default: row = '0;
    endcase
  end

endmodule

// File: rtl/board_renderer.sv
// Two-stage chessboard pixel generator: stage 1 tracks square/art counters and
// fetches the board nibble and art row, stage 2 resolves the pixel colour.
module board_renderer
  import chess_pkg::*;
#(
  parameter int   SQ_SIZE      = 50,
  parameter int   ORIGIN_X     = 120,
  parameter int   ORIGIN_Y     = 40,
  parameter int   BORDER       = 5,
  parameter int   ART_SCALE    = 5,
  parameter int   BLINK_FRAMES = 30,
  parameter logic SYNC_IDLE    = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [9:0]   hcount,
  input  logic [9:0]   vcount,
  input  logic         hsync_in,
  input  logic         vsync_in,
  input  logic         blank_in,
  input  logic [255:0] board,
  input  logic [5:0]   cursor_addr,
  input  logic [5:0]   select_addr,
  input  logic         select_en,
  input  logic [5:0]   last_from,
  input  logic [5:0]   last_to,
  input  logic         last_en,
  input  logic         flip,
  output logic [7:0]   rgb,
  output logic         hsync_out,
  output logic         vsync_out
);

  localparam int SW = $clog2(SQ_SIZE);
  localparam int AW = $clog2(ART_SCALE + 1);
  localparam int FW = 16;

  localparam logic [9:0]    OX      = 10'(ORIGIN_X);
  localparam logic [9:0]    OY      = 10'(ORIGIN_Y);
  localparam logic [SW-1:0] S_LAST  = SW'(SQ_SIZE - 1);
  localparam logic [SW-1:0] B_LO    = SW'(BORDER);
  localparam logic [SW-1:0] B_HI    = SW'(SQ_SIZE - BORDER);
  localparam logic [SW-1:0] ART_HI  = SW'(BORDER + 8 * ART_SCALE);
  localparam logic [AW-1:0] A_LAST  = AW'(ART_SCALE - 1);
  localparam logic [FW-1:0] F_LAST  = FW'((BLINK_FRAMES > 0) ? BLINK_FRAMES - 1 : 0);

  // One axis of the board walk: square index, pixel within square, art cell.
  typedef struct packed {
    logic          in;
    logic [2:0]    sq;
    logic [SW-1:0] pos;
    logic [2:0]    art;
    logic [AW-1:0] sub;
  } axis_t;

  function automatic axis_t axis_step(input axis_t cur, input logic load);
    axis_t nxt;
    nxt = cur;
    if (load) begin
      nxt.in  = 1'b1;
      nxt.sq  = 3'd0;
      nxt.pos = '0;
    end else if (cur.in) begin
      if (cur.pos == S_LAST) begin
        nxt.pos = '0;
        nxt.sq  = cur.sq + 3'd1;
        if (cur.sq == 3'd7) nxt.in = 1'b0;
      end else begin
        nxt.pos = cur.pos + 1'b1;
      end
    end
    // Art cells restart at the first inner pixel so no division is needed.
    if (nxt.pos == B_LO) begin
      nxt.art = 3'd0;
      nxt.sub = '0;
    end else if (cur.sub == A_LAST) begin
      nxt.sub = '0;
      nxt.art = cur.art + 3'd1;
    end else begin
      nxt.sub = cur.sub + 1'b1;
    end
    return nxt;
  endfunction

  axis_t      x_q, y_q, x_nxt, y_nxt;
  logic [5:0] disp_n, idx_n, idx_q;
  square_t    sq_n, sq_q;
  logic [0:7] art_row_n, art_q;
  logic       hs_d1, vs_d1, blank_d1;
  logic [FW-1:0] frame_cnt;
  logic       blink_on;

  always_comb begin
    x_nxt  = axis_step(x_q, hcount == OX);
    y_nxt  = (hcount == 10'd0) ? axis_step(y_q, vcount == OY) : y_q;
    disp_n = {y_nxt.sq, x_nxt.sq};
    idx_n  = flip ? (6'd63 - disp_n) : disp_n;
    sq_n   = square_t'(board[{idx_n, 2'b00} +: 4]);
  end

  piece_art_rom u_art (
    .piece (sq_n.piece),
    .ay    (y_nxt.art),
    .row   (art_row_n)
  );

  // Stage 1: counters and delayed timing signals.
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q      <= '0;
      y_q      <= '0;
      hs_d1    <= SYNC_IDLE;
      vs_d1    <= SYNC_IDLE;
      blank_d1 <= 1'b1;
    end else begin
      // NOTE: non-blocking so each register samples the pre-edge value of the others.
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      hs_d1    <= hsync_in;
      vs_d1    <= vsync_in;
      blank_d1 <= blank_in;
    end
  end

  // NOTE: fetched data carries no reset; in_x/in_y are reset and mask it until valid.
  always_ff @(posedge clk) begin
    sq_q  <= sq_n;
    idx_q <= idx_n;
    art_q <= art_row_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (BLINK_FRAMES != 0 && hcount == 10'd0 && vcount == 10'd0) begin
      if (frame_cnt == F_LAST) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // Stage 2: colour priority.
  logic border, art_valid, art_bit;
  rgb_t sq_colour, colour;

  always_comb begin
    border    = (x_q.pos < B_LO) || (x_q.pos >= B_HI) ||
                (y_q.pos < B_LO) || (y_q.pos >= B_HI);
    art_valid = (x_q.pos >= B_LO) && (x_q.pos < ART_HI) &&
                (y_q.pos >= B_LO) && (y_q.pos < ART_HI);
    art_bit   = art_q[x_q.art];
    sq_colour = (y_q.sq[0] ^ x_q.sq[0]) ? RGB_DARK : RGB_LIGHT;
    colour    = sq_colour;
    if (!x_q.in || !y_q.in || blank_d1) begin
      colour = RGB_BLACK;
    end else if (border) begin
      if (blink_on && idx_q == cursor_addr)
        colour = RGB_CURSOR;
      else if (select_en && idx_q == select_addr)
        colour = RGB_SELECT;
    end else if (art_valid && art_bit && is_piece(sq_q.piece)) begin
      colour = (sq_q.color == COLOR_BLACK) ? RGB_PIECE_BLACK : RGB_PIECE_WHITE;
    end else if (art_valid && sq_q.piece == MARKER) begin
      colour = RGB_BLACK;
    end else if (last_en && (idx_q == last_from || idx_q == last_to)) begin
      colour = RGB_LAST;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb       <= RGB_BLACK;
      hsync_out <= SYNC_IDLE;
      vsync_out <= SYNC_IDLE;
    end else begin
      rgb       <= colour;
      hsync_out <= hs_d1;
      vsync_out <= vs_d1;
    end
  end

endmodule
